// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-128 encryption controller.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ascon_pack;

  localparam int ROUNDS_A       = 12;
  localparam int ROUNDS_B_START = 6;

  localparam logic [3:0] ROUND_FIRST   = 4'd0;
  localparam logic [3:0] ROUND_LAST    = 4'(ROUNDS_A - 1);
  localparam logic [3:0] ROUND_B_FIRST = 4'(ROUNDS_B_START);

  // XOR applied to the state before the round function
  typedef enum logic [1:0] {
    UP_NONE     = 2'b00,
    UP_DATA     = 2'b01,
    UP_KEY      = 2'b10,
    UP_DATA_KEY = 2'b11
  } up_mode_t;

  // XOR applied to the state after the round function
  typedef enum logic [1:0] {
    DOWN_NONE   = 2'b00,
    DOWN_KEY    = 2'b01,
    DOWN_DOMAIN = 2'b10
  } down_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_AD,
    ST_AD,
    ST_WAIT_PT,
    ST_PT,
    ST_FINAL,
    ST_DONE
  } ctrl_state_t;

  // Full set of controller outputs, registered as one word
  typedef struct packed {
    logic       ready;
    logic       select;
    logic       enable;
    logic [3:0] round;
    up_mode_t   up;
    down_mode_t down;
    logic       cipher_valid;
    logic       tag_valid;
    logic       busy;
  } ctrl_out_t;

endpackage

// File: rtl/round_counter.sv
// Round index counter: loadable, saturating at the last round.
// Latency: count updates one cycle after load/inc; count_next is combinational.
// Backpressure: none; holds its value when neither load nor inc is set.
module round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  output logic [3:0] count,
  output logic [3:0] count_next,
  output logic       last
);

  // Next value: load wins, increment stops at the last round so 12..15 are never reached
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (inc && (count != ROUND_LAST)) begin
      count_next = count + 4'd1;
    end
  end

  // Counter register
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      count <= ROUND_FIRST;
    end else begin
      count <= count_next;
    end
  end

  assign last = (count == ROUND_LAST);

endmodule

// File: rtl/ascon_control.sv
// ASCON-128 encryption sequencer: INIT, associated data, plaintext, FINAL, tag strobe.
// Latency: outputs registered, valid in the cycle of the state they describe.
// Backpressure: data_ready only in the two wait states; data_valid ignored elsewhere.
module ascon_control
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       last_i,
  output logic       data_ready_o,
  output logic       select_o,
  output logic       enable_o,
  output logic [3:0] round_o,
  output logic [1:0] etat_up_o,
  output logic [1:0] etat_down_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  ctrl_state_t state, state_n;
  logic        last_q, last_n;
  logic        cnt_load, cnt_inc, cnt_last;
  logic [3:0]  cnt_load_val, cnt, cnt_next;
  logic        hs;
  ctrl_out_t   out_q;

  // Moore decode of one state/round pair; the registered copy of the next pair drives the pins
  function automatic ctrl_out_t decode(ctrl_state_t st, logic [3:0] rnd, logic last_blk);
    ctrl_out_t o;
    o = '0;
    o.busy = (st != ST_IDLE);
    case (st)
      ST_INIT: begin
        o.enable = 1'b1;
        o.round  = rnd;
        o.select = (rnd == ROUND_FIRST);
        if (rnd == ROUND_LAST) o.down = DOWN_KEY;
      end
      ST_WAIT_AD, ST_WAIT_PT: begin
        o.ready = 1'b1;
      end
      ST_AD: begin
        o.enable = 1'b1;
        o.round  = rnd;
        if (rnd == ROUND_B_FIRST) o.up = UP_DATA;
        if ((rnd == ROUND_LAST) && last_blk) o.down = DOWN_DOMAIN;
      end
      ST_PT: begin
        o.enable = 1'b1;
        o.round  = rnd;
        if (rnd == ROUND_B_FIRST) begin
          o.up           = UP_DATA;
          o.cipher_valid = 1'b1;
        end
      end
      ST_FINAL: begin
        o.enable = 1'b1;
        o.round  = rnd;
        if (rnd == ROUND_FIRST) begin
          o.up           = UP_DATA_KEY;
          o.cipher_valid = 1'b1;
        end
        if (rnd == ROUND_LAST) o.down = DOWN_KEY;
      end
      ST_DONE: begin
        o.tag_valid = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  // ready is a registered decode of the wait states, so this is a state-qualified handshake
  assign hs = data_valid_i && data_ready_o;

  round_counter u_round_counter (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .load       (cnt_load),
    .load_val   (cnt_load_val),
    .inc        (cnt_inc),
    .count      (cnt),
    .count_next (cnt_next),
    .last       (cnt_last)
  );

  // Next state, counter control and the last-block latch
  always_comb begin
    state_n      = state;
    last_n       = last_q;
    cnt_load     = 1'b0;
    cnt_load_val = ROUND_FIRST;
    cnt_inc      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_n      = ST_INIT;
          cnt_load     = 1'b1;
          cnt_load_val = ROUND_FIRST;
        end
      end
      ST_INIT: begin
        if (cnt_last) state_n = ST_WAIT_AD;
        else          cnt_inc = 1'b1;
      end
      ST_WAIT_AD: begin
        if (hs) begin
          state_n      = ST_AD;
          cnt_load     = 1'b1;
          cnt_load_val = ROUND_B_FIRST;
          last_n       = last_i;
        end
      end
      ST_AD: begin
        if (cnt_last) state_n = last_q ? ST_WAIT_PT : ST_WAIT_AD;
        else          cnt_inc = 1'b1;
      end
      ST_WAIT_PT: begin
        if (hs) begin
          cnt_load = 1'b1;
          if (last_i) begin
            state_n      = ST_FINAL;
            cnt_load_val = ROUND_FIRST;
          end else begin
            state_n      = ST_PT;
            cnt_load_val = ROUND_B_FIRST;
          end
        end
      end
      ST_PT: begin
        if (cnt_last) state_n = ST_WAIT_PT;
        else          cnt_inc = 1'b1;
      end
      ST_FINAL: begin
        if (cnt_last) state_n = ST_DONE;
        else          cnt_inc = 1'b1;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, latched last flag and registered outputs; reset clears everything at once
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state  <= ST_IDLE;
      last_q <= 1'b0;
      out_q  <= '0;
    end else begin
      state  <= state_n;
      last_q <= last_n;
      out_q  <= decode(state_n, cnt_next, last_n);
    end
  end

  assign data_ready_o   = out_q.ready;
  assign select_o       = out_q.select;
  assign enable_o       = out_q.enable;
  assign round_o        = out_q.round;
  assign etat_up_o      = out_q.up;
  assign etat_down_o    = out_q.down;
  assign cipher_valid_o = out_q.cipher_valid;
  assign tag_valid_o    = out_q.tag_valid;
  assign busy_o         = out_q.busy;

endmodule

// File: tb/tb_ascon_control.sv
`timescale 1ns/1ps
module tb_ascon_control;

  logic       clock_i = 1'b0;
  logic       resetb_i, start_i, data_valid_i, last_i;
  logic       data_ready_o, select_o, enable_o, cipher_valid_o, tag_valid_o, busy_o;
  logic [3:0] round_o;
  logic [1:0] etat_up_o, etat_down_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected active (non-idle, non-wait) cycles, in order: {sel,en,round,up,down,cv,tag}
  logic [11:0] exp_q[$];
  logic [11:0] act_v;

  always #5 clock_i = ~clock_i;

  ascon_control dut (
    .clock_i        (clock_i),
    .resetb_i       (resetb_i),
    .start_i        (start_i),
    .data_valid_i   (data_valid_i),
    .last_i         (last_i),
    .data_ready_o   (data_ready_o),
    .select_o       (select_o),
    .enable_o       (enable_o),
    .round_o        (round_o),
    .etat_up_o      (etat_up_o),
    .etat_down_o    (etat_down_o),
    .cipher_valid_o (cipher_valid_o),
    .tag_valid_o    (tag_valid_o),
    .busy_o         (busy_o)
  );

  function automatic logic [11:0] vec(logic sel, logic en, logic [3:0] rnd,
                                      logic [1:0] up, logic [1:0] dn, logic cv, logic tag);
    return {sel, en, rnd, up, dn, cv, tag};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: one encryption is INIT(12), each AD block 6 rounds, each non-last
  // PT block 6 rounds, FINAL(12), then one tag cycle.
  task automatic push_txn(int nad, int npt);
    for (int r = 0; r < 12; r++)
      exp_q.push_back(vec(r == 0, 1'b1, 4'(r), 2'b00, (r == 11) ? 2'b01 : 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < nad; i++)
      for (int r = 6; r < 12; r++)
        exp_q.push_back(vec(1'b0, 1'b1, 4'(r), (r == 6) ? 2'b01 : 2'b00,
                            (r == 11 && i == nad - 1) ? 2'b10 : 2'b00, 1'b0, 1'b0));
    for (int j = 0; j < npt - 1; j++)
      for (int r = 6; r < 12; r++)
        exp_q.push_back(vec(1'b0, 1'b1, 4'(r), (r == 6) ? 2'b01 : 2'b00, 2'b00, r == 6, 1'b0));
    for (int r = 0; r < 12; r++)
      exp_q.push_back(vec(1'b0, 1'b1, 4'(r), (r == 0) ? 2'b11 : 2'b00,
                          (r == 11) ? 2'b01 : 2'b00, r == 0, 1'b0));
    exp_q.push_back(vec(1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 1'b0, 1'b1));
  endtask

  // Monitor: idle and wait cycles must be quiet, active cycles must match the model in order
  initial begin
    forever begin
      @(negedge clock_i);
      act_v = {select_o, enable_o, round_o, etat_up_o, etat_down_o, cipher_valid_o, tag_valid_o};
      if (!busy_o) begin
        check("idle_outputs", 32'({data_ready_o, act_v}), 32'd0);
      end else if (data_ready_o) begin
        check("wait_outputs", 32'(act_v), 32'd0);
      end else if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_active_cycle: got 0x%0h, expected no activity at %0t", act_v, $time);
      end else begin
        check("active_cycle", 32'(act_v), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic start_txn(bit timed);
    @(negedge clock_i);
    start_i      = 1'b1;
    data_valid_i = timed ? 1'b0 : 1'b1;
    last_i       = 1'b0;
    @(negedge clock_i);
    start_i = 1'b0;
    if (timed) begin
      check("t_select_c1", 32'(select_o), 32'd1);
      for (int c = 1; c <= 12; c++) begin
        if (c > 1) @(negedge clock_i);
        check("t_round", 32'(round_o), 32'(c - 1));
        check("t_down", 32'(etat_down_o), (c == 12) ? 32'd1 : 32'd0);
      end
      @(negedge clock_i);
      check("t_ready_c13", 32'(data_ready_o), 32'd1);
    end else begin
      // data_valid held high and start_i toggled through INIT must change nothing
      for (int c = 1; c < 12; c++) begin
        start_i = 1'($urandom % 2);
        @(negedge clock_i);
      end
      start_i = 1'b0;
    end
  endtask

  // Entered at a negedge; returns at the negedge whose inputs complete the handshake
  task automatic send_block(bit lst, bit final_blk, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      last_i  = lst;
      start_i = final_blk ? 1'b0 : 1'($urandom % 2);
      if (data_ready_o) data_valid_i = (($urandom % 4) != 0);
      else              data_valid_i = 1'($urandom % 2);
      if (data_valid_i && data_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock_i);
    end
  endtask

  task automatic run_txn(int nad, int npt, bit timed, bit abort);
    bit ok;
    push_txn(nad, npt);
    start_txn(timed);
    for (int i = 0; i < nad + npt; i++) begin
      if (i > 0) @(negedge clock_i);
      send_block((i < nad) ? (i == nad - 1) : (i == nad + npt - 1), i == nad + npt - 1, ok);
      if (!ok) begin
        n_tests++;
        n_fail++;
        $display("FAIL handshake_timeout: block %0d never accepted at %0t", i, $time);
        exp_q.delete();
        resetb_i = 1'b0;
        repeat (2) @(negedge clock_i);
        resetb_i     = 1'b1;
        data_valid_i = 1'b0;
        start_i      = 1'b0;
        return;
      end
    end
    @(negedge clock_i);
    data_valid_i = 1'b0;
    start_i      = 1'b0;
    if (abort) begin
      repeat (5) @(negedge clock_i);
      check("abort_at_final_r5", 32'({busy_o, enable_o, round_o}), 32'({1'b1, 1'b1, 4'd5}));
      #2 resetb_i = 1'b0;
      #1;
      check("abort_outputs_zero",
            32'({data_ready_o, select_o, enable_o, round_o, etat_up_o, etat_down_o,
                 cipher_valid_o, tag_valid_o, busy_o}), 32'd0);
      exp_q.delete();
      @(negedge clock_i);
      @(negedge clock_i);
      resetb_i = 1'b1;
      for (int k = 0; k < 15; k++) begin
        @(negedge clock_i);
        check("no_tag_after_abort", 32'({tag_valid_o, busy_o}), 32'd0);
      end
    end else begin
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clock_i);
      check("txn_drained", 32'(exp_q.size()), 32'd0);
      @(negedge clock_i);
      check("idle_after_done", 32'(busy_o), 32'd0);
    end
  endtask

  initial begin
    resetb_i     = 1'b0;
    start_i      = 1'b0;
    data_valid_i = 1'b0;
    last_i       = 1'b0;
    repeat (2) @(negedge clock_i);
    check("reset_outputs",
          32'({data_ready_o, select_o, enable_o, round_o, etat_up_o, etat_down_o,
               cipher_valid_o, tag_valid_o, busy_o}), 32'd0);
    @(negedge clock_i);
    resetb_i = 1'b1;

    run_txn(1, 2, 1'b1, 1'b0);
    run_txn(1, 1, 1'b0, 1'b1);
    run_txn(2, 1, 1'b1, 1'b0);
    for (int t = 0; t < 12; t++)
      run_txn(int'($urandom_range(3, 1)), int'($urandom_range(3, 1)), 1'b0, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
